// File: rtl/alu_req_initiator_pkg.sv
// Shared ALU configuration: operation encoding, data width and the
// initiator FSM state type.
package alu_req_initiator_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned OP_W       = 4;

  // Encoding 4'hF is never assigned to an operation.
  typedef enum logic [OP_W-1:0] {
    ADD = 4'h0,
    SUB = 4'h1,
    AND = 4'h2,
    OR  = 4'h3,
    XOR = 4'h4,
    SLL = 4'h5,
    SRL = 4'h6,
    SLT = 4'h7
  } ALUOp;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } alu_init_state_t;

  function automatic logic is_legal_op(ALUOp op);
    case (op)
      ADD, SUB, AND, OR, XOR, SLL, SRL, SLT: return 1'b1;
      default:                               return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_req_initiator_if.sv
// Request, ALU operand/result and response signals of the ALU initiator.
interface alu_req_initiator_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TAG_W      = 4
);
  import alu_req_initiator_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_a;
  logic [DATA_WIDTH-1:0] req_b;
  ALUOp                  req_op;
  logic [TAG_W-1:0]      req_tag;

  logic [DATA_WIDTH-1:0] operandA;
  logic [DATA_WIDTH-1:0] operandB;
  ALUOp                  operation;
  logic [DATA_WIDTH-1:0] aluResult;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic [TAG_W-1:0]      rsp_tag;
  logic                  rsp_err;

  modport master (
    input  req_valid, req_a, req_b, req_op, req_tag, aluResult, rsp_ready,
    output req_ready, operandA, operandB, operation,
           rsp_valid, rsp_result, rsp_tag, rsp_err
  );

  modport slave (
    output req_valid, req_a, req_b, req_op, req_tag, aluResult, rsp_ready,
    input  req_ready, operandA, operandB, operation,
           rsp_valid, rsp_result, rsp_tag, rsp_err
  );

endinterface

// File: rtl/alu_req_initiator.sv
// Initiator side of the ALU interface: accepts requests, drives registered
// operands, samples the result after ALU_LAT cycles and returns it tagged.
module alu_req_initiator #(
  parameter int unsigned DATA_WIDTH = alu_req_initiator_pkg::DATA_WIDTH,
  parameter int unsigned ALU_LAT    = 0,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_req_initiator_if.master  bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);
  import alu_req_initiator_pkg::*;

  localparam int unsigned WAIT_W = 3;

  alu_init_state_t       stateQ, stateD;
  logic [WAIT_W-1:0]     waitCnt;
  logic [DATA_WIDTH-1:0] opAQ, opBQ, rspResultQ;
  ALUOp                  opQ;
  logic [TAG_W-1:0]      tagQ;
  logic                  rspErrQ;
  logic [CNT_W-1:0]      opCountQ;

  logic reqReady, accept, reqLegal, rspFire, capture;

  assign reqLegal = is_legal_op(bus.req_op);

  // Next state; a response handshake may accept a new request in the same cycle.
  always_comb begin
    stateD   = stateQ;
    reqReady = 1'b0;
    rspFire  = 1'b0;
    capture  = 1'b0;
    accept   = 1'b0;
    case (stateQ)
      IDLE: reqReady = 1'b1;
      WAIT: begin
        capture = (waitCnt == '0);
        if (capture) stateD = RESP;
      end
      RESP: begin
        reqReady = bus.rsp_ready;
        rspFire  = bus.rsp_ready;
        if (rspFire) stateD = IDLE;
      end
      default: stateD = IDLE;
    endcase
    accept = bus.req_valid && reqReady;
    if (accept) stateD = reqLegal ? WAIT : RESP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  // Operand, response and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opAQ       <= '0;
      opBQ       <= '0;
      opQ        <= ADD;
      tagQ       <= '0;
      waitCnt    <= '0;
      rspResultQ <= '0;
      rspErrQ    <= 1'b0;
      opCountQ   <= '0;
    end else begin
      if (accept) begin
        tagQ <= bus.req_tag;
        if (reqLegal) begin
          opAQ    <= bus.req_a;
          opBQ    <= bus.req_b;
          opQ     <= bus.req_op;
          waitCnt <= WAIT_W'(ALU_LAT);
        end else begin
          rspResultQ <= '0;
          rspErrQ    <= 1'b1;
        end
      end else if (capture) begin
        rspResultQ <= bus.aluResult;
        rspErrQ    <= 1'b0;
      end else if (stateQ == WAIT) begin
        waitCnt <= waitCnt - WAIT_W'(1);
      end
      if (rspFire) opCountQ <= opCountQ + CNT_W'(1);
    end
  end

  assign bus.req_ready  = reqReady;
  assign bus.operandA   = opAQ;
  assign bus.operandB   = opBQ;
  assign bus.operation  = opQ;
  assign bus.rsp_valid  = (stateQ == RESP);
  assign bus.rsp_result = rspResultQ;
  assign bus.rsp_tag    = tagQ;
  assign bus.rsp_err    = rspErrQ;
  assign busy           = (stateQ != IDLE);
  assign op_count       = opCountQ;

endmodule

// File: tb/tb_alu_req_initiator.sv
// Bench for alu_req_initiator: a zero-latency instance fed by a combinational
// ALU model and a two-stage instance fed by a delay-line ALU model.
module tb_alu_req_initiator;
  import alu_req_initiator_pkg::*;

  localparam int unsigned DW   = 32;
  localparam int unsigned TW   = 4;
  localparam int unsigned CW   = 16;
  localparam int unsigned LAT2 = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nTests = 0;
  int nFail  = 0;

  logic          busy0, busy2;
  logic [CW-1:0] cnt0, cnt2;
  logic [CW-1:0] cntModel0 = '0;
  logic [CW-1:0] cntModel2 = '0;
  logic [DW-1:0] lastA0 = '0, lastB0 = '0;
  logic [3:0]    lastOp0 = 4'h0;

  alu_req_initiator_if #(.DATA_WIDTH(DW), .TAG_W(TW)) bus0 ();
  alu_req_initiator_if #(.DATA_WIDTH(DW), .TAG_W(TW)) bus2 ();

  alu_req_initiator #(.DATA_WIDTH(DW), .ALU_LAT(0), .TAG_W(TW), .CNT_W(CW)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .busy(busy0), .op_count(cnt0));
  alu_req_initiator #(.DATA_WIDTH(DW), .ALU_LAT(LAT2), .TAG_W(TW), .CNT_W(CW)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2), .busy(busy2), .op_count(cnt2));

  // Reference arithmetic by opcode number: 0..7 are the named operations.
  function automatic logic [DW-1:0] alu_ref(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[4:0];
      4'd6: return a >> b[4:0];
      4'd7: return ($signed(a) < $signed(b)) ? DW'(1) : DW'(0);
      default: return '0;
    endcase
  endfunction

  always_comb bus0.aluResult = alu_ref(bus0.operation, bus0.operandA, bus0.operandB);

  logic [DW-1:0] dline [LAT2];
  always @(posedge clk) begin
    dline[0] <= alu_ref(bus2.operation, bus2.operandA, bus2.operandB);
    for (int i = 1; i < LAT2; i++) dline[i] <= dline[i-1];
  end
  assign bus2.aluResult = dline[LAT2-1];

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic          err;
  } exp_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus0.req_valid = 1'b0; bus0.rsp_ready = 1'b0; bus0.req_a = '0; bus0.req_b = '0;
    bus0.req_op = ADD; bus0.req_tag = '0;
    bus2.req_valid = 1'b0; bus2.rsp_ready = 1'b0; bus2.req_a = '0; bus2.req_b = '0;
    bus2.req_op = ADD; bus2.req_tag = '0;
    rst_n = 1'b0;
    repeat (3) tick();
    nTests++; if (bus0.rsp_valid !== 1'b0) begin nFail++; $display("FAIL rst_rsp_valid got=%0h exp=0", bus0.rsp_valid); end
    nTests++; if (bus0.operandA !== '0 || bus0.operandB !== '0) begin nFail++; $display("FAIL rst_operands got=%0h/%0h exp=0/0", bus0.operandA, bus0.operandB); end
    nTests++; if (bus0.operation !== ADD) begin nFail++; $display("FAIL rst_operation got=%0h exp=0", bus0.operation); end
    nTests++; if (bus0.rsp_result !== '0 || bus0.rsp_tag !== '0 || bus0.rsp_err !== 1'b0) begin nFail++; $display("FAIL rst_rsp got=%0h/%0h/%0h exp=0/0/0", bus0.rsp_result, bus0.rsp_tag, bus0.rsp_err); end
    nTests++; if (cnt0 !== '0 || busy0 !== 1'b0) begin nFail++; $display("FAIL rst_cnt_busy got=%0h/%0h exp=0/0", cnt0, busy0); end
    rst_n = 1'b1;
    tick();
    nTests++; if (bus0.req_ready !== 1'b1) begin nFail++; $display("FAIL rst_req_ready got=%0h exp=1", bus0.req_ready); end
  endtask

  // One request on the zero-latency instance, consumer always ready.
  task automatic run_op0(input string name, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [TW-1:0] tag);
    logic          legal;
    int            expLat;
    int            t;
    logic [DW-1:0] expA, expB, expRes;
    logic [3:0]    expOp;
    legal  = (op <= 4'd7);
    expLat = legal ? 2 : 1;
    expRes = legal ? alu_ref(op, a, b) : '0;
    expA   = legal ? a : lastA0;
    expB   = legal ? b : lastB0;
    expOp  = legal ? op : lastOp0;
    bus0.req_op = ALUOp'(op); bus0.req_a = a; bus0.req_b = b; bus0.req_tag = tag;
    bus0.req_valid = 1'b1; bus0.rsp_ready = 1'b1;
    #1;
    nTests++; if (bus0.req_ready !== 1'b1) begin nFail++; $display("FAIL %s_req_ready got=%0h exp=1", name, bus0.req_ready); end
    tick();
    bus0.req_valid = 1'b0;
    nTests++; if (bus0.operandA !== expA || bus0.operandB !== expB || bus0.operation !== ALUOp'(expOp)) begin
      nFail++; $display("FAIL %s_operands got=%0h/%0h/%0h exp=%0h/%0h/%0h", name, bus0.operandA, bus0.operandB, bus0.operation, expA, expB, expOp);
    end
    if (legal) begin lastA0 = a; lastB0 = b; lastOp0 = op; end
    t = 1;
    while (!bus0.rsp_valid && t < 10) begin tick(); t++; end
    nTests++; if (t != expLat) begin nFail++; $display("FAIL %s_latency got=%0d exp=%0d", name, t, expLat); end
    nTests++; if (bus0.rsp_result !== expRes || bus0.rsp_tag !== tag || bus0.rsp_err !== !legal) begin
      nFail++; $display("FAIL %s_rsp got=%0h/%0h/%0h exp=%0h/%0h/%0h", name, bus0.rsp_result, bus0.rsp_tag, bus0.rsp_err, expRes, tag, !legal);
    end
    tick();
    cntModel0++;
    nTests++; if (cnt0 !== cntModel0 || bus0.rsp_valid !== 1'b0) begin
      nFail++; $display("FAIL %s_count got=%0d/%0h exp=%0d/0", name, cnt0, bus0.rsp_valid, cntModel0);
    end
  endtask

  task automatic test_basic();
    run_op0("add5_7", 4'd0, 32'd5, 32'd7, 4'd3);
    run_op0("sub0_1", 4'd1, 32'd0, 32'd1, 4'd4);
    nTests++; if (alu_ref(4'd1, 32'd0, 32'd1) !== bus0.rsp_result) begin nFail++; $display("FAIL sub_hold got=%0h exp=ffffffff", bus0.rsp_result); end
  endtask

  task automatic test_illegal();
    run_op0("pre_add", 4'd0, 32'd5, 32'd7, 4'd2);
    run_op0("illegal", 4'hF, 32'd1234, 32'd5678, 4'd9);
  endtask

  task automatic test_stall();
    int t;
    bus0.req_op = ADD; bus0.req_a = 32'd1; bus0.req_b = 32'd1; bus0.req_tag = 4'd6;
    bus0.req_valid = 1'b1; bus0.rsp_ready = 1'b0;
    tick();
    bus0.req_valid = 1'b0;
    t = 0;
    while (!bus0.rsp_valid && t < 10) begin tick(); t++; end
    for (int k = 0; k < 3; k++) begin
      nTests++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_result !== 32'd2 || bus0.rsp_tag !== 4'd6 || bus0.req_ready !== 1'b0) begin
        nFail++; $display("FAIL stall_hold%0d got=%0h/%0h/%0h/%0h exp=1/2/6/0", k, bus0.rsp_valid, bus0.rsp_result, bus0.rsp_tag, bus0.req_ready);
      end
      tick();
    end
    bus0.rsp_ready = 1'b1;
    #1;
    nTests++; if (bus0.req_ready !== 1'b1) begin nFail++; $display("FAIL stall_req_ready got=%0h exp=1", bus0.req_ready); end
    tick();
    cntModel0++;
    nTests++; if (bus0.rsp_valid !== 1'b0 || cnt0 !== cntModel0) begin nFail++; $display("FAIL stall_done got=%0h/%0d exp=0/%0d", bus0.rsp_valid, cnt0, cntModel0); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] rq[$];
    logic [TW-1:0] tq[$];
    int            cq[$];
    int            acc2;
    bit            sent;
    acc2 = -1; sent = 1'b0;
    bus0.req_op = ADD; bus0.req_a = 32'd1; bus0.req_b = 32'd2; bus0.req_tag = 4'd1;
    bus0.req_valid = 1'b1; bus0.rsp_ready = 1'b1;
    tick();
    bus0.req_a = 32'd3; bus0.req_b = 32'd4; bus0.req_tag = 4'd2;
    for (int k = 0; k < 12; k++) begin
      if (bus0.rsp_valid) begin rq.push_back(bus0.rsp_result); tq.push_back(bus0.rsp_tag); cq.push_back(cyc); end
      if (bus0.req_valid && bus0.req_ready) begin acc2 = cyc; sent = 1'b1; end
      tick();
      if (sent) bus0.req_valid = 1'b0;
    end
    nTests++;
    if (rq.size() != 2) begin
      nFail++; $display("FAIL b2b_count got=%0d exp=2", rq.size());
    end else begin
      if (rq[0] !== 32'd3 || rq[1] !== 32'd7 || tq[0] !== 4'd1 || tq[1] !== 4'd2) begin
        nFail++; $display("FAIL b2b_data got=%0h,%0h tags %0h,%0h exp=3,7 tags 1,2", rq[0], rq[1], tq[0], tq[1]);
      end
      nTests++; if (cq[1] - cq[0] != 2 || acc2 != cq[0]) begin
        nFail++; $display("FAIL b2b_timing got=gap %0d accept %0d exp=gap 2 accept %0d", cq[1] - cq[0], acc2, cq[0]);
      end
    end
    cntModel0 += 2;
    nTests++; if (cnt0 !== cntModel0) begin nFail++; $display("FAIL b2b_opcount got=%0d exp=%0d", cnt0, cntModel0); end
  endtask

  // Random requests, gaps and consumer stalls against an in-order scoreboard.
  task automatic test_random();
    exp_t          expQ[$];
    exp_t          e, held;
    bit            pending, stalled;
    logic [3:0]    op;
    pending = 1'b0; stalled = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!pending && ($urandom % 2 == 0)) begin
        op = ($urandom % 4 == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
        bus0.req_op = ALUOp'(op); bus0.req_a = DW'($urandom); bus0.req_b = DW'($urandom);
        if ($urandom % 3 == 0) bus0.req_b = DW'($urandom_range(0, 40));
        bus0.req_tag = TW'($urandom); bus0.req_valid = 1'b1; pending = 1'b1;
      end
      bus0.rsp_ready = (c >= 380) || ($urandom % 4 != 0);
      #1;
      if (stalled) begin
        nTests++; if (bus0.rsp_valid !== 1'b1 || bus0.rsp_result !== held.res || bus0.rsp_tag !== held.tag || bus0.rsp_err !== held.err) begin
          nFail++; $display("FAIL rnd_stable got=%0h/%0h/%0h/%0h exp=1/%0h/%0h/%0h", bus0.rsp_valid, bus0.rsp_result, bus0.rsp_tag, bus0.rsp_err, held.res, held.tag, held.err);
        end
        stalled = 1'b0;
      end
      if (bus0.rsp_valid) begin
        if (bus0.rsp_ready) begin
          nTests++;
          if (expQ.size() == 0) begin
            nFail++; $display("FAIL rnd_spurious got=%0h exp=none", bus0.rsp_result);
          end else begin
            e = expQ.pop_front();
            if (bus0.rsp_result !== e.res || bus0.rsp_tag !== e.tag || bus0.rsp_err !== e.err) begin
              nFail++; $display("FAIL rnd_rsp got=%0h/%0h/%0h exp=%0h/%0h/%0h", bus0.rsp_result, bus0.rsp_tag, bus0.rsp_err, e.res, e.tag, e.err);
            end
          end
          cntModel0++;
        end else begin
          held.res = bus0.rsp_result; held.tag = bus0.rsp_tag; held.err = bus0.rsp_err; stalled = 1'b1;
        end
      end
      if (bus0.req_valid && bus0.req_ready) begin
        op = 4'(bus0.req_op);
        e.err = (op > 4'd7);
        e.res = e.err ? '0 : alu_ref(op, bus0.req_a, bus0.req_b);
        e.tag = bus0.req_tag;
        expQ.push_back(e);
        pending = 1'b0;
      end
      tick();
      if (!pending) bus0.req_valid = 1'b0;
      if (c >= 380) pending = 1'b1;
    end
    bus0.req_valid = 1'b0;
    nTests++; if (expQ.size() != 0 || cnt0 !== cntModel0) begin
      nFail++; $display("FAIL rnd_drain got=%0d left cnt %0d exp=0 left cnt %0d", expQ.size(), cnt0, cntModel0);
    end
  endtask

  // One legal request on the two-stage instance.
  task automatic run_op2(input string name, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b, input logic [TW-1:0] tag);
    int t;
    bus2.req_op = ALUOp'(op); bus2.req_a = a; bus2.req_b = b; bus2.req_tag = tag;
    bus2.req_valid = 1'b1; bus2.rsp_ready = 1'b1;
    tick();
    bus2.req_valid = 1'b0;
    t = 1;
    while (!bus2.rsp_valid && t < 12) begin
      if (bus2.operandA !== a) begin nTests++; nFail++; $display("FAIL %s_opA_hold got=%0h exp=%0h", name, bus2.operandA, a); end
      tick(); t++;
    end
    nTests++; if (t != LAT2 + 2) begin nFail++; $display("FAIL %s_latency got=%0d exp=%0d", name, t, LAT2 + 2); end
    nTests++; if (bus2.rsp_result !== alu_ref(op, a, b) || bus2.rsp_tag !== tag || bus2.rsp_err !== 1'b0) begin
      nFail++; $display("FAIL %s_rsp got=%0h/%0h/%0h exp=%0h/%0h/0", name, bus2.rsp_result, bus2.rsp_tag, bus2.rsp_err, alu_ref(op, a, b), tag);
    end
    tick();
    cntModel2++;
    nTests++; if (cnt2 !== cntModel2) begin nFail++; $display("FAIL %s_count got=%0d exp=%0d", name, cnt2, cntModel2); end
  endtask

  task automatic test_latency2();
    for (int k = 0; k < 6; k++)
      run_op2("lat2", 4'($urandom_range(0, 7)), DW'($urandom), DW'($urandom_range(0, 31)), TW'(k));
  endtask

  task automatic test_reset_mid();
    bit seen;
    bus2.req_op = ADD; bus2.req_a = 32'd10; bus2.req_b = 32'd20; bus2.req_tag = 4'd5;
    bus2.req_valid = 1'b1; bus2.rsp_ready = 1'b1;
    tick();
    bus2.req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    nTests++; if (bus2.rsp_valid !== 1'b0 || busy2 !== 1'b0) begin nFail++; $display("FAIL rstmid_flags got=%0h/%0h exp=0/0", bus2.rsp_valid, busy2); end
    nTests++; if (bus2.operandA !== '0 || bus2.operandB !== '0) begin nFail++; $display("FAIL rstmid_operands got=%0h/%0h exp=0/0", bus2.operandA, bus2.operandB); end
    tick();
    rst_n = 1'b1;
    cntModel0 = '0; cntModel2 = '0;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus2.rsp_valid) seen = 1'b1;
      tick();
    end
    nTests++; if (seen) begin nFail++; $display("FAIL rstmid_ghost got=response exp=none"); end
    run_op2("post_rst", 4'd0, 32'd1, 32'd1, 4'd7);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_illegal();
    test_stall();
    test_back_to_back();
    test_random();
    test_latency2();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
